// File: rtl/pipe_out_arbiter_if.sv
// pipe_out_arbiter_if: endpoint and source-bank handshake bundle for pipe_out_arbiter
interface pipe_out_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_SRC-1:0]            src_enable;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_read;
  logic                          pipe_out_read;
  logic [DATA_WIDTH-1:0]         pipe_out_data;
  logic                          pipe_out_ready;
  logic                          abort;
  modport master (
    input  src_enable, src_ready, src_data, pipe_out_read, abort,
    output src_read, pipe_out_data, pipe_out_ready
  );
  modport slave (
    output src_enable, src_ready, src_data, pipe_out_read, abort,
    input  src_read, pipe_out_data, pipe_out_ready
  );
endinterface

// File: rtl/pipe_out_arbiter.sv
// pipe_out_arbiter: block-locked round-robin sharing of one Pipe Out endpoint between NUM_SRC sources
module pipe_out_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 1024,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  pipe_out_arbiter_if.master         bus,
  input  logic                       stat_clear,
  output logic                       grant_valid,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic [CNT_WIDTH-1:0]       block_count,
  output logic [CNT_WIDTH-1:0]       stray_count,
  output logic [CNT_WIDTH-1:0]       abort_count
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int WW = $clog2(BLOCK_WORDS);
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, pick;
  logic [WW-1:0] word_cnt;
  logic [NUM_SRC-1:0] req;
  logic [DATA_WIDTH-1:0] src_words [NUM_SRC];
  logic take, rd_ok, last, inc_stray, inc_abort;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
    assign src_words[i] = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign req         = bus.src_enable & bus.src_ready;
  assign grant_valid = state != IDLE;
  assign take        = state == IDLE && !bus.abort && |req;
  assign rd_ok       = state == GRANT && !bus.abort && bus.pipe_out_read;
  assign last        = rd_ok && word_cnt == WW'(BLOCK_WORDS - 1);
  assign inc_stray   = bus.pipe_out_read && state != GRANT;
  assign inc_abort   = bus.abort && grant_valid;
  assign bus.src_read      = {NUM_SRC{rd_ok}} & (NUM_SRC'(1) << grant_idx);
  assign bus.pipe_out_data = grant_valid ? src_words[grant_idx] : '0;
  // Walk downward so the nearest set bit above ptr is the last (winning) assignment.
  always_comb begin
    pick = ptr;
    for (int k = NUM_SRC; k >= 1; k--)
      if (req[(int'(ptr) + k) % NUM_SRC]) pick = IW'((int'(ptr) + k) % NUM_SRC);
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (take ? GRANT : IDLE) :
              state == GRANT ? (bus.abort ? IDLE : last ? HOLD : GRANT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr                <= IW'(NUM_SRC - 1);
      grant_idx          <= '0;
      word_cnt           <= '0;
      bus.pipe_out_ready <= 1'b0;
    end else begin
      if (take) grant_idx <= pick;
      word_cnt <= take ? '0 : rd_ok ? word_cnt + 1'b1 : word_cnt;
      if (grant_valid && state_n == IDLE) ptr <= grant_idx;
      bus.pipe_out_ready <= take ? 1'b1 : (rd_ok || bus.abort) ? 1'b0 : bus.pipe_out_ready;
    end
  end
  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      block_count <= '0;
      stray_count <= '0;
      abort_count <= '0;
    end else begin
      block_count <= bump(block_count, last);
      stray_count <= bump(stray_count, inc_stray);
      abort_count <= bump(abort_count, inc_abort);
    end
  end
endmodule

// File: tb/tb_pipe_out_arbiter.sv
// tb_pipe_out_arbiter: directed stimulus checked every cycle against a block-level arbitration model
module tb_pipe_out_arbiter;
  localparam int N = 4, DW = 32, BW = 1024, CW = 4, MAXC = 15;
  logic clk = 1'b0, reset = 1'b1, stat_clear = 1'b0;
  logic grant_valid;
  logic [1:0] grant_idx;
  logic [CW-1:0] block_count, stray_count, abort_count;
  int tot = 0, bad = 0, cyc = 0;
  int pulses [N];
  int m_ph = 0, m_idx = 0, m_ptr = N - 1, m_left = 0, m_rdy = 0, m_blk = 0, m_str = 0, m_abt = 0;
  bit armed = 1'b0;
  int g, w, p0, p2, p3;
  int order [5];

  pipe_out_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) bus ();

  pipe_out_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .BLOCK_WORDS(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stat_clear(stat_clear),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .block_count(block_count), .stray_count(stray_count), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int sat(int c, int inc);
    return stat_clear ? 0 : (c + inc > MAXC ? MAXC : c + inc);
  endfunction

  // Model: phase 0 = no grant, 1 = block in progress, 2 = one-cycle tail after the last word.
  task automatic model_step();
    int b = 0, s = 0, a = 0;
    logic [N-1:0] req;
    req = bus.src_enable & bus.src_ready;
    if (reset) begin
      m_ph = 0; m_idx = 0; m_ptr = N - 1; m_left = 0; m_rdy = 0;
      m_blk = 0; m_str = 0; m_abt = 0; armed = 1'b1;
      return;
    end
    if (m_ph == 0) begin
      s = int'(bus.pipe_out_read);
      if (!bus.abort && req != 0) begin
        for (int k = 1; k <= N; k++)
          if (req[(m_ptr + k) % N]) begin m_idx = (m_ptr + k) % N; break; end
        m_ph = 1; m_left = BW; m_rdy = 1;
      end
    end else if (m_ph == 2) begin
      s = int'(bus.pipe_out_read); a = int'(bus.abort); m_ph = 0; m_ptr = m_idx;
    end else if (bus.abort) begin
      a = 1; m_ph = 0; m_rdy = 0; m_ptr = m_idx;
    end else if (bus.pipe_out_read) begin
      m_left--; m_rdy = 0;
      if (m_left == 0) begin m_ph = 2; b = 1; end
    end
    m_blk = sat(m_blk, b);
    m_str = sat(m_str, s);
    m_abt = sat(m_abt, a);
  endtask

  function automatic void compare();
    logic [N-1:0] er;
    logic [DW-1:0] ed;
    er = (m_ph == 1 && !bus.abort && bus.pipe_out_read) ? N'(1) << m_idx : '0;
    ed = (m_ph != 0) ? {8'(m_idx), 24'(cyc)} : '0;
    chk("src_read", 64'(bus.src_read), 64'(er));
    chk("pipe_out_data", 64'(bus.pipe_out_data), 64'(ed));
    chk("pipe_out_ready", 64'(bus.pipe_out_ready), 64'(m_rdy));
    chk("grant_valid", 64'(grant_valid), 64'(m_ph != 0));
    chk("grant_idx", 64'(grant_idx), 64'(m_idx));
    chk("block_count", 64'(block_count), 64'(m_blk));
    chk("stray_count", 64'(stray_count), 64'(m_str));
    chk("abort_count", 64'(abort_count), 64'(m_abt));
    for (int i = 0; i < N; i++) pulses[i] += int'(bus.src_read[i]);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.src_data[i*DW +: DW] = {8'(i), 24'(cyc)};
  endtask

  task automatic tick();
    @(negedge clk);
    if (armed) compare();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    drive_data();
  endtask

  task automatic wait_grant(output int gi, output int wc);
    wc = 0;
    while (!bus.pipe_out_ready && wc < 40) begin tick(); wc++; end
    chk("grant_timeout", 64'(bus.pipe_out_ready), 64'(1));
    gi = int'(grant_idx);
  endtask

  task automatic do_block(input bit drop, input bit hold_rd, output int gi, output int wc);
    wait_grant(gi, wc);
    if (drop) bus.src_ready = '0;
    bus.pipe_out_read = 1'b1;
    repeat (BW) tick();
    if (hold_rd) tick();
    bus.pipe_out_read = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"}, 64'(bus.pipe_out_ready), 64'(0));
    chk({tag, "_valid"}, 64'(grant_valid), 64'(0));
    chk({tag, "_idx"}, 64'(grant_idx), 64'(0));
    chk({tag, "_read"}, 64'(bus.src_read), 64'(0));
    chk({tag, "_data"}, 64'(bus.pipe_out_data), 64'(0));
    chk({tag, "_cnts"}, 64'({block_count, stray_count, abort_count}), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) pulses[i] = 0;
    bus.src_enable = '0; bus.src_ready = '0; bus.pipe_out_read = 1'b0; bus.abort = 1'b0;
    drive_data();
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    // single ready source: grant one cycle after request, full block
    bus.src_enable = 4'hF; bus.src_ready = 4'b0001; p0 = pulses[0];
    do_block(1'b1, 1'b0, g, w);
    chk("t1_latency", 64'(w), 64'(1));
    chk("t1_grant", 64'(g), 64'(0));
    chk("t1_pulses0", 64'(pulses[0] - p0), 64'(BW));
    chk("t1_blocks", 64'(block_count), 64'(1));
    // all ready: rotation 0,1,2,3,0 from reset
    reset = 1'b1; tick(); reset = 1'b0;
    bus.src_ready = 4'hF;
    for (int b = 0; b < 5; b++) begin
      do_block(1'b0, 1'b0, g, w);
      order[b] = g;
      chk("t2_gap", 64'(w), 64'(1));
      if (b == 3) chk("t2_blocks4", 64'(block_count), 64'(4));
    end
    for (int b = 0; b < 5; b++) chk("t2_order", 64'(order[b]), 64'(b % 4));
    // enable mask 1010 with all ready
    bus.src_enable = 4'b1010; p0 = pulses[0]; p2 = pulses[2];
    for (int b = 0; b < 3; b++) begin
      do_block(b == 2, 1'b0, g, w);
      order[b] = g;
    end
    chk("t3_order0", 64'(order[0]), 64'(1));
    chk("t3_order1", 64'(order[1]), 64'(3));
    chk("t3_order2", 64'(order[2]), 64'(1));
    chk("t3_src0_quiet", 64'(pulses[0] - p0), 64'(0));
    chk("t3_src2_quiet", 64'(pulses[2] - p2), 64'(0));
    // stray reads, saturation, clear priority
    bus.src_enable = 4'hF;
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    chk("t4_cleared", 64'(block_count), 64'(0));
    bus.pipe_out_read = 1'b1; repeat (5) tick(); bus.pipe_out_read = 1'b0;
    chk("t4_stray5", 64'(stray_count), 64'(5));
    bus.src_ready = 4'b0001;
    do_block(1'b1, 1'b1, g, w);
    chk("t4_stray6", 64'(stray_count), 64'(6));
    chk("t4_block", 64'(block_count), 64'(1));
    bus.pipe_out_read = 1'b1; repeat (12) tick();
    chk("t4_saturate", 64'(stray_count), 64'(MAXC));
    stat_clear = 1'b1; tick(); stat_clear = 1'b0; bus.pipe_out_read = 1'b0;
    chk("t4_clear_prio", 64'(stray_count), 64'(0));
    // abort mid-block, abort in IDLE, abort with a same-cycle read
    reset = 1'b1; tick(); reset = 1'b0;
    bus.src_ready = 4'b0100;
    wait_grant(g, w);
    chk("t5_grant2", 64'(g), 64'(2));
    bus.src_ready = '0; bus.pipe_out_read = 1'b1; repeat (100) tick(); bus.pipe_out_read = 1'b0;
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("t5_abort_idle", 64'(grant_valid), 64'(0));
    chk("t5_abort_cnt", 64'(abort_count), 64'(1));
    chk("t5_abort_ready", 64'(bus.pipe_out_ready), 64'(0));
    bus.src_ready = 4'b1100; bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("t5_idle_abort_nogrant", 64'(grant_valid), 64'(0));
    chk("t5_idle_abort_cnt", 64'(abort_count), 64'(1));
    tick();
    chk("t5_regrant", 64'(grant_valid), 64'(1));
    chk("t5_next_src3", 64'(grant_idx), 64'(3));
    p3 = pulses[3];
    bus.pipe_out_read = 1'b1; bus.abort = 1'b1; tick();
    bus.pipe_out_read = 1'b0; bus.abort = 1'b0; bus.src_ready = '0;
    chk("t5_no_read_on_abort", 64'(pulses[3] - p3), 64'(0));
    chk("t5_abort_cnt2", 64'(abort_count), 64'(2));
    // reset mid-block restores source 0 priority and restarts the word count
    bus.src_ready = 4'b0010;
    do_block(1'b1, 1'b0, g, w);
    chk("t6_grant1", 64'(g), 64'(1));
    bus.src_ready = 4'b0100;
    wait_grant(g, w);
    chk("t6_grant2", 64'(g), 64'(2));
    bus.src_ready = '0; bus.pipe_out_read = 1'b1; repeat (500) tick(); bus.pipe_out_read = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk_reset_vals("t6");
    bus.src_ready = 4'hF; p0 = pulses[0];
    do_block(1'b1, 1'b0, g, w);
    chk("t6_grant0", 64'(g), 64'(0));
    chk("t6_pulses0", 64'(pulses[0] - p0), 64'(BW));
    chk("t6_blocks", 64'(block_count), 64'(1));
    tick();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
